rv32i_alu_arbiter: RTL
======================

// Module: rv32i_alu_arbiter
// PURPOSE
//   Shares one rv32i_alu instance between N_REQ requesters (e.g. EX stage, AGU, CSR unit).
//   - Round-robin arbitration with valid/ready request handshake.
//   - One registered response slot, tagged with the requester ID.
//   - Throughput: one op per cycle when the consumer keeps rsp_ready high.
// PARAMETERS
//   N_REQ   default 3   number of requesters (2..8)
//   ID_W    default $clog2(N_REQ)   width of the requester ID tag (derived; do not override)
// PORTS
//   clk         in   1          clock; all state updates on posedge
//   rst         in   1          asynchronous, active-high reset
//   req_valid   in   N_REQ      per-requester operation valid
//   req_ready   out  N_REQ      per-requester accept; at most one bit high (one-hot or zero)
//   req_op      in   N_REQ*4    ALU op for requester i, in bits [4i+3:4i], rv32i_pkg::alu_op_e encoding
//   req_a       in   N_REQ*32   operand A for requester i, in bits [32i+31:32i]
//   req_b       in   N_REQ*32   operand B for requester i, same packing as req_a
//   rsp_valid   out  1          response slot holds a result
//   rsp_ready   in   1          consumer accepts the response
//   rsp_id      out  ID_W       index of the requester that issued the result
//   rsp_result  out  32         ALU result
// BEHAVIOUR
//   Reset
//     - rsp_valid=0, rsp_id=0, rsp_result=0, rr_ptr=0.
//     - req_ready is combinational and is 0 while rst is high.
//     - Asserting reset mid-operation discards the slot contents; that result is lost and is not replayed.
//   Slot
//     - State EMPTY(rsp_valid=0) / FULL(rsp_valid=1).
//     - can_accept = !rsp_valid || rsp_ready.
//   Arbitration (combinational)
//     - grant = first valid requester found by searching from rr_ptr upward, wrapping N_REQ-1 -> 0.
//     - req_ready[grant] = can_accept. All other req_ready bits are 0.
//   Transfer
//     - A transfer occurs when req_valid[g] && req_ready[g].
//     - Next edge: rsp_valid=1, rsp_id=g, rsp_result=ALU(op_g, a_g, b_g).
//     - Latency 1 cycle. Operands are sampled only at the transfer edge.
//   Drain
//     - rsp_valid && rsp_ready with no new transfer: slot goes to EMPTY.
//     - Drain and a new transfer in the same cycle: slot reloads and stays FULL (no bubble).
//   Pointer
//     - On transfer, rr_ptr = (g==N_REQ-1) ? 0 : g+1. Otherwise rr_ptr holds.
//   Stall
//     - FULL && !rsp_ready: all req_ready=0.
//     - Slot contents and rr_ptr are frozen.
//     - Requesters must hold valid and operands stable until accepted.
//   Illegal op
//     - Op codes 10..15 are passed through. The ALU returns 0 for them; the arbiter flags no error.
//   No valid requests: grant is don't-care, req_ready=0, and no state changes.
// CONFIGURATION
//   Macro RV32I_ALU_ARB_LOCK_EN
//   - Defined: adds input port req_lock [N_REQ].
//     - A transfer from g with req_lock[g]=1 sets lock_valid=1, lock_id=g (reset: 0/0).
//     - While lock_valid, only g may be granted; other requesters wait even if valid.
//     - Lock ends on the first transfer from g with req_lock[g]=0, or any cycle with req_valid[g]=0.
//     - When the lock ends, rr_ptr = g+1 (with wrap).
//   - Undefined: no req_lock port and no lock state; pure round-robin.
// STRUCTURE
//   rv32i_pkg (shared)
//     - alu_op_e enum: ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9.
//     - XLEN=32 and ALU_OP_W=4 constants.
//   Sub-module rv32i_rr_arbiter
//     - Parameterised N, holds the pointer and produces a one-hot grant.
//     - Reused later by the memory-port arbiter.
//   Instantiates the existing rv32i_alu unchanged.
//   The operand mux is indexed by the binary grant.
// TESTING
//   1. Reset, then req0 ADD a=5 b=7 with rsp_ready=1
//      -> req_ready[0]=1 the same cycle; next cycle rsp_valid=1, rsp_id=0, rsp_result=12.
//   2. All 3 requesters valid continuously, rsp_ready=1
//      -> grants 0,1,2,0,1,2 on consecutive cycles; one rsp per cycle, no bubbles.
//   3. rsp_ready=0 for 4 cycles with slot FULL (req1 SUB 3-5 = 0xFFFFFFFE)
//      -> req_ready=0, rsp_result held; on release the next grant follows rr_ptr.
//   4. Check SRA 0x80000000 >>> 31 = 0xFFFFFFFF, SLTU 1<0xFFFFFFFF = 1, SLT = 0,
//      op 4'hF = 0; each result returns with the correct rsp_id.
//   5. Assert rst while FULL and requests are pending
//      -> rsp_valid=0 and rr_ptr=0 at once (asynchronously); after deassertion, the first grant goes to the lowest valid requester.
//   6. (LOCK_EN) req2 locked for 3 ops while req0 is valid
//      -> grants 2,2,2 then 0; lock releases early if req2 drops valid.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: ALU op encoding and datapath widths.
package rv32i_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned ALU_OP_W = 4;

  // Codes 10..15 are not listed; the ALU returns 0 for them.
  typedef enum logic [ALU_OP_W-1:0] {
    ADD  = 4'd0,
    SUB  = 4'd1,
    SLL  = 4'd2,
    SLT  = 4'd3,
    SLTU = 4'd4,
    XOR  = 4'd5,
    SRL  = 4'd6,
    SRA  = 4'd7,
    OR   = 4'd8,
    AND  = 4'd9
  } alu_op_e;

endpackage

// File: rtl/rv32i_alu.sv
// Combinational RV32I integer ALU. Unlisted op codes produce 0.
module rv32i_alu
  import rv32i_pkg::*;
(
  input  logic [ALU_OP_W-1:0] op,
  input  logic [XLEN-1:0]     a,
  input  logic [XLEN-1:0]     b,
  output logic [XLEN-1:0]     result
);

  logic [4:0] shamt;
  assign shamt = b[4:0];

  // Decode the op and compute the result.
  always_comb begin
    result = '0;
    case (alu_op_e'(op))
      ADD:     result = a + b;
      SUB:     result = a - b;
      SLL:     result = a << shamt;
      SLT:     result = XLEN'($signed(a) < $signed(b));
      SLTU:    result = XLEN'(a < b);
      XOR:     result = a ^ b;
      SRL:     result = a >> shamt;
      SRA:     result = $unsigned($signed(a) >>> shamt);
      OR:      result = a | b;
      AND:     result = a & b;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/rv32i_rr_arbiter.sv
// Generic round-robin arbiter: holds the priority pointer and returns a one-hot
// grant plus its binary index. The search starts at the pointer and wraps.
module rv32i_rr_arbiter #(
  parameter  int unsigned N  = 3,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          advance,     // grant taken this cycle: restart after grant_idx
  input  logic          load_en,     // restart after load_after instead
  input  logic [IW-1:0] load_after,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          grant_valid
);

  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] idx;

  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] v);
    return (v == IW'(N - 1)) ? '0 : v + 1'b1;
  endfunction

  // First requester at or after the pointer, wrapping N-1 -> 0.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    idx         = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = IW'((32'(ptr_q) + k) % N);
      if (!grant_valid && req[idx]) begin
        grant_valid = 1'b1;
        grant[idx]  = 1'b1;
        grant_idx   = idx;
      end
    end
  end

  // Pointer moves past the winner on a transfer, or past an explicit index on load.
  always_comb begin
    ptr_d = ptr_q;
    if (advance) begin
      ptr_d = wrap_inc(grant_idx);
    end else if (load_en) begin
      ptr_d = wrap_inc(load_after);
    end
  end

  // Pointer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/rv32i_alu_arbiter.sv
// Shares one rv32i_alu between N_REQ requesters with round-robin arbitration
// and a single registered, ID-tagged response slot.
// Optional feature: define RV32I_ALU_ARB_LOCK_EN to add req_lock, which lets a
// requester keep the ALU for back-to-back operations.
module rv32i_alu_arbiter
  import rv32i_pkg::*;
#(
  parameter  int unsigned N_REQ = 3,
  localparam int unsigned ID_W  = $clog2(N_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  output logic [N_REQ-1:0]          req_ready,
  input  logic [N_REQ*ALU_OP_W-1:0] req_op,
  input  logic [N_REQ*XLEN-1:0]     req_a,
  input  logic [N_REQ*XLEN-1:0]     req_b,
`ifdef RV32I_ALU_ARB_LOCK_EN
  input  logic [N_REQ-1:0]          req_lock,
`endif
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [XLEN-1:0]           rsp_result
);

  logic [N_REQ-1:0]    arb_req;
  logic [N_REQ-1:0]    grant;
  logic [ID_W-1:0]     grant_idx;
  logic                grant_valid;
  logic                can_accept;
  logic                transfer;
  logic                load_en;
  logic [ID_W-1:0]     load_after;

  logic [ALU_OP_W-1:0] sel_op;
  logic [XLEN-1:0]     sel_a, sel_b;
  logic [XLEN-1:0]     alu_result;

  logic                rsp_valid_q;
  logic [ID_W-1:0]     rsp_id_q;
  logic [XLEN-1:0]     rsp_result_q;

`ifdef RV32I_ALU_ARB_LOCK_EN
  logic                lock_valid_q, lock_valid_d;
  logic [ID_W-1:0]     lock_id_q, lock_id_d;
  logic                lock_end;
  logic [N_REQ-1:0]    lock_mask;

  // While locked only the owner is visible to the arbiter; the lock drops on an
  // unlocked transfer from the owner or as soon as the owner stops requesting.
  always_comb begin
    lock_mask            = '0;
    lock_mask[lock_id_q] = 1'b1;
    arb_req    = lock_valid_q ? (req_valid & lock_mask) : req_valid;
    lock_end   = lock_valid_q &&
                 (!req_valid[lock_id_q] || (transfer && !req_lock[lock_id_q]));
    load_en    = lock_end;
    load_after = lock_id_q;
    lock_valid_d = lock_valid_q;
    lock_id_d    = lock_id_q;
    if (lock_end) begin
      lock_valid_d = 1'b0;
    end
    if (transfer && req_lock[grant_idx]) begin
      lock_valid_d = 1'b1;
      lock_id_d    = grant_idx;
    end
  end

  // Lock state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_valid_q <= 1'b0;
      lock_id_q    <= '0;
    end else begin
      lock_valid_q <= lock_valid_d;
      lock_id_q    <= lock_id_d;
    end
  end
`else
  assign arb_req    = req_valid;
  assign load_en    = 1'b0;
  assign load_after = '0;
`endif

  rv32i_rr_arbiter #(
    .N (N_REQ)
  ) u_rr (
    .clk         (clk),
    .rst         (rst),
    .req         (arb_req),
    .advance     (transfer),
    .load_en     (load_en),
    .load_after  (load_after),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  // Handshake: the slot can take a new result if empty or draining this cycle.
  always_comb begin
    can_accept = !rsp_valid_q || rsp_ready;
    req_ready  = (grant_valid && can_accept && !rst) ? grant : '0;
    transfer   = |(req_valid & req_ready);
  end

  // Operand mux steered by the binary grant index.
  always_comb begin
    sel_op = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant_idx == ID_W'(i)) begin
        sel_op = req_op[i*ALU_OP_W +: ALU_OP_W];
        sel_a  = req_a[i*XLEN +: XLEN];
        sel_b  = req_b[i*XLEN +: XLEN];
      end
    end
  end

  rv32i_alu u_alu (
    .op     (sel_op),
    .a      (sel_a),
    .b      (sel_b),
    .result (alu_result)
  );

  // Response slot: load on transfer (even while draining), else empty on drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
    end else if (transfer) begin
      rsp_valid_q  <= 1'b1;
      rsp_id_q     <= grant_idx;
      rsp_result_q <= alu_result;
    end else if (rsp_ready) begin
      rsp_valid_q  <= 1'b0;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;

endmodule
